// File: rtl/page_stream_queue_slack.sv
// page_stream_queue_slack: circular token queue with registered head,
// early back-pressure leaving SLACK free slots, and sticky overflow.
module page_stream_queue_slack #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4,
  parameter int SLACK = 0
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [WIDTH-1:0]           qin_d,
  input  logic                       qin_e,
  input  logic                       qin_v,
  output logic                       qin_b,
  output logic [WIDTH-1:0]           qout_d,
  output logic                       qout_e,
  output logic                       qout_v,
  input  logic                       qout_b,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       overflow
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH:0]   r_mem [DEPTH];
  logic [AW-1:0]    r_wr;
  logic [AW-1:0]    r_rd;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_hd;
  logic             r_he;
  logic             r_hv;
  logic             r_ovf;

  logic             w_full;
  logic             w_deq;
  logic             w_enq;
  logic [AW-1:0]    w_rd_n;
  logic [CW-1:0]    w_cnt_n;
  logic [CW-1:0]    w_rest;
  logic             w_load;

  function automatic logic [AW-1:0] inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign w_full  = (r_cnt == CW'(DEPTH));
  assign w_deq   = r_hv & ~qout_b;
  assign w_enq   = qin_v & (~w_full | w_deq);
  assign w_rd_n  = w_deq ? inc(r_rd) : r_rd;
  assign w_cnt_n = r_cnt + CW'(w_enq) - CW'(w_deq);
  // entries left behind the head once this cycle's dequeue is taken
  assign w_rest  = r_cnt - CW'(w_deq);
  assign w_load  = ~r_hv | w_deq;

  assign qin_b    = (r_cnt >= CW'(DEPTH - SLACK));
  assign qout_d   = r_hd;
  assign qout_e   = r_he;
  assign qout_v   = r_hv;
  assign count    = r_cnt;
  assign overflow = r_ovf;

  always_ff @(posedge clock) begin
    if (!reset && w_enq) begin
      r_mem[r_wr] <= {qin_e, qin_d};
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
      r_ovf <= 1'b0;
    end else begin
      r_rd  <= w_rd_n;
      r_cnt <= w_cnt_n;
      if (w_enq) begin
        r_wr <= inc(r_wr);
      end
      if (qin_v && w_full && !w_deq) begin
        r_ovf <= 1'b1;
      end
    end
  end

  // head mirrors the oldest stored token; a write into an empty
  // buffer is taken straight from the input one cycle later
  always_ff @(posedge clock) begin
    if (reset) begin
      r_hv <= 1'b0;
      r_hd <= '0;
      r_he <= 1'b0;
    end else if (w_load) begin
      r_hv <= (w_cnt_n != '0);
      if (w_rest == '0) begin
        if (w_enq) begin
          {r_he, r_hd} <= {qin_e, qin_d};
        end
      end else begin
        {r_he, r_hd} <= r_mem[w_rd_n];
      end
    end
  end

endmodule
